coin_score_hud: RTL and testbench

- Consumer of the coin tally produced by the coin-collection block.
- Watches the 8-bit `coin_score` bus and converts each new value to three BCD digits with a serial shift-add-3 (double-dabble) state machine.
- Drives the HUD sprite/hex digit selects.
- Raises one-cycle `coin_event` and `extra_life` pulses for the audio and lives logic.

---
 rtl/coin_score_hud.sv | 129 ++++++++++++
 tb/tb_coin_score_hud.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/coin_score_hud.sv
// Coin tally to three-digit BCD converter for the HUD, with one-cycle
// coin_event / extra_life pulses for the audio and lives logic.
module coin_score_hud #(
  parameter int SCORE_W            = 8,
  parameter int LIFE_STEP_HUNDREDS = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SCORE_W-1:0] coin_score,
  input  logic               clear,
  output logic [3:0]         digit_hund,
  output logic [3:0]         digit_tens,
  output logic [3:0]         digit_ones,
  output logic               bcd_valid,
  output logic               busy,
  output logic               coin_event,
  output logic               extra_life
);

  localparam int SR_W  = 12 + SCORE_W;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SCORE_W-1:0] last_q;
  logic [SR_W-1:0]    sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               up_q;
  logic [3:0]         hund_q;
  logic [3:0]         tens_q;
  logic [3:0]         ones_q;
  logic               valid_q;
  logic               busy_q;
  logic               coin_event_q;
  logic               extra_life_q;

  // Add-3 correction on each BCD nibble above the binary field, then shift.
  logic [SR_W-1:0] sr_adj;
  logic [SR_W-1:0] sr_d;

  assign sr_adj[SCORE_W-1:0] = sr_q[SCORE_W-1:0];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_add3
      assign sr_adj[SCORE_W + 4*gi +: 4] =
        (sr_q[SCORE_W + 4*gi +: 4] >= 4'd5) ? (sr_q[SCORE_W + 4*gi +: 4] + 4'd3)
                                            : sr_q[SCORE_W + 4*gi +: 4];
    end
  endgenerate

  assign sr_d = {sr_adj[SR_W-2:0], 1'b0};

  // Widened to 5 bits so old hundreds + step cannot wrap.
  logic [4:0] hund_new_w;
  logic [4:0] hund_need_w;
  logic       life_hit;

  assign hund_new_w  = {1'b0, sr_q[SR_W-1 -: 4]};
  assign hund_need_w = {1'b0, hund_q} + 5'(LIFE_STEP_HUNDREDS);
  assign life_hit    = up_q && (hund_new_w >= hund_need_w);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q      <= IDLE;
      last_q       <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      up_q         <= 1'b0;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      valid_q      <= 1'b1;
      busy_q       <= 1'b0;
      coin_event_q <= 1'b0;
      extra_life_q <= 1'b0;
    end else begin
      coin_event_q <= 1'b0;
      extra_life_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_score != last_q) begin
            last_q       <= coin_score;
            sr_q         <= {12'b0, coin_score};
            cnt_q        <= '0;
            up_q         <= (coin_score > last_q);
            coin_event_q <= (coin_score > last_q);
            busy_q       <= 1'b1;
            valid_q      <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          hund_q       <= sr_q[SR_W-1 -: 4];
          tens_q       <= sr_q[SR_W-5 -: 4];
          ones_q       <= sr_q[SR_W-9 -: 4];
          extra_life_q <= life_hit;
          busy_q       <= 1'b0;
          valid_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign digit_hund = hund_q;
  assign digit_tens = tens_q;
  assign digit_ones = ones_q;
  assign bcd_valid  = valid_q;
  assign busy       = busy_q;
  assign coin_event = coin_event_q;
  assign extra_life = extra_life_q;

endmodule

// File: tb/tb_coin_score_hud.sv
// Bench for coin_score_hud: directed scenarios plus random traffic, every
// cycle compared against an arithmetic countdown model of the converter.
module tb_coin_score_hud;

  localparam int SCORE_W = 8;
  localparam int LIFE    = 1;

  logic               clk;
  logic               reset_n;
  logic [SCORE_W-1:0] coin_score;
  logic               clear;
  logic [3:0]         digit_hund;
  logic [3:0]         digit_tens;
  logic [3:0]         digit_ones;
  logic               bcd_valid;
  logic               busy;
  logic               coin_event;
  logic               extra_life;

  coin_score_hud #(
    .SCORE_W            (SCORE_W),
    .LIFE_STEP_HUNDREDS (LIFE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin_score (coin_score),
    .clear      (clear),
    .digit_hund (digit_hund),
    .digit_tens (digit_tens),
    .digit_ones (digit_ones),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .coin_event (coin_event),
    .extra_life (extra_life)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ev_seen = 0;

  // Reference model: a conversion is simply "result appears 9 edges later".
  int m_left, m_last, m_cap;
  int m_hund, m_tens, m_ones;
  bit m_up, m_ev, m_xl, m_busy, m_valid;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit clr, input int cs);
    int nh;
    if (!rn || clr) begin
      m_left = 0; m_last = 0; m_cap = 0; m_up = 0;
      m_hund = 0; m_tens = 0; m_ones = 0;
      m_ev = 0; m_xl = 0; m_busy = 0; m_valid = 1;
    end else begin
      m_ev = 0;
      m_xl = 0;
      if (m_left == 0) begin
        if (cs != m_last) begin
          m_up    = (cs > m_last);
          m_ev    = m_up;
          m_cap   = cs;
          m_last  = cs;
          m_left  = 9;
          m_busy  = 1;
          m_valid = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          nh      = m_cap / 100;
          m_xl    = m_up && (nh >= m_hund + LIFE);
          m_hund  = nh;
          m_tens  = (m_cap / 10) % 10;
          m_ones  = m_cap % 10;
          m_busy  = 0;
          m_valid = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit rn, input bit clr, input int cs);
    reset_n    = rn;
    clear      = clr;
    coin_score = SCORE_W'(cs);
    @(posedge clk);
    model_step(rn, clr, cs);
    @(negedge clk);
    cyc++;
    if (coin_event) ev_seen++;
    check_val("hund",  digit_hund, m_hund);
    check_val("tens",  digit_tens, m_tens);
    check_val("ones",  digit_ones, m_ones);
    check_val("valid", bcd_valid,  m_valid);
    check_val("busy",  busy,       m_busy);
    check_val("event", coin_event, m_ev);
    check_val("xlife", extra_life, m_xl);
  endtask

  task automatic hold(input int n, input int cs);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, cs);
  endtask

  initial begin
    int cs;
    int r;
    reset_n = 1'b0; clear = 1'b0; coin_score = '0;
    @(negedge clk);

    // Reset, then idle with score 0.
    cycle(1'b0, 1'b0, 0);
    hold(20, 0);
    $display("[TB] reset/idle done cyc=%0d", cyc);

    // 0 -> 1
    hold(12, 1);
    $display("[TB] 0->1 digits %0d%0d%0d", digit_hund, digit_tens, digit_ones);

    // 99 -> 100 crosses a hundreds boundary.
    hold(12, 99);
    hold(12, 100);
    $display("[TB] 99->100 digits %0d%0d%0d", digit_hund, digit_tens, digit_ones);

    // 255 -> 0 wrap.
    hold(12, 255);
    hold(12, 0);
    $display("[TB] 255->0 digits %0d%0d%0d", digit_hund, digit_tens, digit_ones);

    // Change during SHIFT is picked up only after the first conversion.
    hold(12, 10);
    ev_seen = 0;
    hold(3, 11);
    hold(22, 12);
    check_val("two_events", ev_seen, 2);
    $display("[TB] 10->11->12 digits %0d%0d%0d", digit_hund, digit_tens, digit_ones);

    // Clear mid-conversion of 255, then recapture of 255.
    hold(12, 0);
    hold(4, 255);
    cycle(1'b1, 1'b1, 255);
    hold(12, 255);
    $display("[TB] clear/recapture digits %0d%0d%0d", digit_hund, digit_tens, digit_ones);

    // Random traffic.
    cs = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 250) cs = (cs + int'($urandom_range(1, 3))) % 256;
      else if (r < 320) cs = int'($urandom_range(0, 255));
      else if (r < 330) cs = (cs + 100) % 256;
      if (r >= 990) cycle(1'b0, 1'b0, cs);
      else if (r >= 975) cycle(1'b1, 1'b1, cs);
      else cycle(1'b1, 1'b0, cs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
